inv_mix_columns_seq: RTL



---
 rtl/inv_mix_columns_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : inv_mix_columns_seq
// Description : Column-serial AES decryption round back-end. Captures the
//               inverse-S-box-substituted state (optionally XORed with the
//               round key), applies InvMixColumns one 32-bit column per
//               clock, and presents the result on a valid/ready handshake.
//               The final round bypasses InvMixColumns.
// Build macro : ADD_ROUND_KEY_EN - when defined, the capture XORs in_key
//               into the state (AddRoundKey fused ahead of InvMixColumns).
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               in_valid  - in_data/in_key/in_last valid
//               in_ready  - block can accept (IDLE only)
//               in_data   - 128-bit substituted state, s(0,0) in [127:120]
//               in_key    - 128-bit round key, same byte order
//               in_last   - final round, skip InvMixColumns
//               out_valid - out_data valid, held until accepted
//               out_ready - downstream accepts
//               out_data  - registered round result
//               busy      - block in progress
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MIX  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic   [1:0]   r_col;
  logic   [127:0] r_st;
  logic   [127:0] w_capture;
  logic   [127:0] w_st_mixed;
  logic   [31:0]  w_col_in;
  logic   [31:0]  w_col_out;
  logic           w_accept;

  // Multiply by x (0x02) in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; row 0 is the most significant byte.
  // Each coefficient is assembled from the x2/x4/x8 chain of its byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef ADD_ROUND_KEY_EN
  assign w_capture = in_data ^ in_key;
`else
  // Key is applied elsewhere in this build; the port is kept for a uniform
  // interface.
  logic w_unused_key;
  assign w_unused_key = ^in_key;
  assign w_capture    = in_data;
`endif

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_col_out = inv_mix_col(w_col_in);

  // Column select and write-back for the column currently being mixed.
  always_comb begin
    w_col_in   = r_st[127:96];
    w_st_mixed = r_st;
    case (r_col)
      2'd0: begin
        w_col_in           = r_st[127:96];
        w_st_mixed[127:96] = w_col_out;
      end
      2'd1: begin
        w_col_in          = r_st[95:64];
        w_st_mixed[95:64] = w_col_out;
      end
      2'd2: begin
        w_col_in          = r_st[63:32];
        w_st_mixed[63:32] = w_col_out;
      end
      default: begin
        w_col_in         = r_st[31:0];
        w_st_mixed[31:0] = w_col_out;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = in_last ? S_DONE : S_MIX;
      S_MIX:   if (r_col == 2'd3) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= 2'd0;
      r_st    <= 128'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_st  <= w_capture;
        r_col <= 2'd0;
      end else if (r_state == S_MIX) begin
        r_st  <= w_st_mixed;
        r_col <= r_col + 2'd1;  // wraps back to 0 after column 3
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_st;

endmodule
`default_nettype wire
